// File: rtl/arcade_input_ctrl_pkg.sv
// Shared constants, key-state bundle and coin FSM states for arcade_input_ctrl.
// Optional coin request queue: define COIN_QUEUE_EN.
package arcade_input_pkg;

   localparam logic [7:0] SC_UP      = 8'h75;
   localparam logic [7:0] SC_DOWN    = 8'h72;
   localparam logic [7:0] SC_LEFT    = 8'h6B;
   localparam logic [7:0] SC_RIGHT   = 8'h74;
   localparam logic [7:0] SC_FIRE    = 8'h29;
   localparam logic [7:0] SC_BOMB    = 8'h14;
   localparam logic [7:0] SC_START1  = 8'h16;
   localparam logic [7:0] SC_START2  = 8'h1E;
   localparam logic [7:0] SC_COIN_A  = 8'h2E;
   localparam logic [7:0] SC_COIN_B  = 8'h36;
   localparam logic [7:0] SC_S1COIN  = 8'h05;
   localparam logic [7:0] SC_S2COIN  = 8'h06;
   localparam logic [7:0] SC_SERVICE = 8'h1B;
   localparam logic [7:0] SC_PAUSE   = 8'h4D;

   localparam int JB_RIGHT  = 0;
   localparam int JB_LEFT   = 1;
   localparam int JB_DOWN   = 2;
   localparam int JB_UP     = 3;
   localparam int JB_FIRE   = 4;
   localparam int JB_BOMB   = 5;
   localparam int JB_S1COIN = 6;
   localparam int JB_S2COIN = 7;
   localparam int JB_COIN   = 8;
   localparam int JB_PAUSE  = 9;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } coin_state_e;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fire;
      logic bomb;
      logic start1;
      logic start2;
      logic coin;
      logic s1coin;
      logic s2coin;
      logic service;
      logic pause;
   } keys_t;

   // Directional keys and bomb ignore the extended prefix; all others need ext=0.
   function automatic keys_t key_decode(
      input keys_t      cur,
      input logic       ext,
      input logic [7:0] code,
      input logic       pr
   );
      keys_t k;
      k = cur;
      unique case (1'b1)
         (code == SC_UP):                          k.up      = pr;
         (code == SC_DOWN):                        k.down    = pr;
         (code == SC_LEFT):                        k.left    = pr;
         (code == SC_RIGHT):                       k.right   = pr;
         (code == SC_BOMB):                        k.bomb    = pr;
         (!ext && code == SC_FIRE):                k.fire    = pr;
         (!ext && code == SC_START1):              k.start1  = pr;
         (!ext && code == SC_START2):              k.start2  = pr;
         (!ext && (code == SC_COIN_A ||
                   code == SC_COIN_B)):            k.coin    = pr;
         (!ext && code == SC_S1COIN):              k.s1coin  = pr;
         (!ext && code == SC_S2COIN):              k.s2coin  = pr;
         (!ext && code == SC_SERVICE):             k.service = pr;
         (!ext && code == SC_PAUSE):               k.pause   = pr;
         default:                                  k = cur;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// Control-input bundle between hps_io side (master) and arcade_input_ctrl (slave).
interface arcade_input_ctrl_if;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic        rotate;
   logic        pause_clr;
   logic [3:0]  joystick;
   logic [3:0]  controls;
   logic        coin;
   logic        service;
   logic        pause;

   modport master (
      output ps2_key, joystick_0, joystick_1, rotate, pause_clr,
      input  joystick, controls, coin, service, pause
   );

   modport slave (
      input  ps2_key, joystick_0, joystick_1, rotate, pause_clr,
      output joystick, controls, coin, service, pause
   );
endinterface

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// Coin request -> fixed-width, gap-separated coin pulse FSM.
// Define COIN_QUEUE_EN to queue up to 3 requests arriving during PULSE/GAP.
module coin_pulser
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC = 1800000,
   parameter int COIN_GAP_CYC   = 1800000,
   parameter int CNT_W          = 21
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic req,
   output logic coin
);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(COIN_GAP_CYC - 1);

   coin_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             coin_q, coin_d;
   logic [1:0]       pending;
   logic             pend_inc, pend_dec;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      coin_d   = coin_q;
      pend_inc = 1'b0;
      pend_dec = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req || pending != 2'd0) begin
               cnt_d    = PULSE_LD;
               coin_d   = 1'b1;
               state_d  = PULSE;
               pend_dec = !req;
            end
         end
         PULSE: begin
            pend_inc = req;
            if (cnt_q == '0) begin
               coin_d  = 1'b0;
               cnt_d   = GAP_LD;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            pend_inc = req;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            coin_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         coin_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coin_q  <= coin_d;
      end
   end

`ifdef COIN_QUEUE_EN
   logic [1:0] pend_q, pend_d;

   always_comb begin
      pend_d = pend_q;
      if (pend_inc && pend_q != 2'd3) begin
         pend_d = pend_q + 2'd1;
      end else if (pend_dec) begin
         pend_d = pend_q - 2'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= 2'd0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;
`else
   logic unused_pend;
   assign unused_pend = pend_inc ^ pend_dec;
   assign pending     = 2'd0;
`endif

   assign coin = coin_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick merge, orientation remap, pause toggle and coin conditioning.
// Define COIN_QUEUE_EN to queue coin requests arriving during a pulse.
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC = 1800000,
   parameter int COIN_GAP_CYC   = 1800000,
   parameter int CNT_W          = 21
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   arcade_input_ctrl_if.slave bus
);

   keys_t      key_q, key_d;
   logic       old_tog_q, armed_q, key_ev;
   logic [9:0] joy;
   logic       up_r, down_r, left_r, right_r;
   logic [3:0] joy_q, joy_d;
   logic [3:0] ctl_q, ctl_d;
   logic       service_q;
   logic       pause_q, pause_d, pause_lvl, pause_lvl_q;
   logic       coin_lvl, coin_lvl_q, coin_req;
   logic       unused_joy;

   assign unused_joy = ^{bus.joystick_0[15:10], bus.joystick_1[15:10]};

   always_comb begin
      key_ev = armed_q && (old_tog_q != bus.ps2_key[10]);
      key_d  = key_q;
      if (key_ev) begin
         key_d = key_decode(key_q, bus.ps2_key[8],
                            bus.ps2_key[7:0], bus.ps2_key[9]);
      end

      joy     = bus.joystick_0[9:0] | bus.joystick_1[9:0];
      up_r    = key_q.up    | joy[JB_UP];
      down_r  = key_q.down  | joy[JB_DOWN];
      left_r  = key_q.left  | joy[JB_LEFT];
      right_r = key_q.right | joy[JB_RIGHT];

      // Rotated cabinet: up<-left, right<-up, down<-right, left<-down.
      joy_d = bus.rotate ? {left_r, up_r, right_r, down_r}
                         : {up_r, right_r, down_r, left_r};

      ctl_d = {key_q.start1 | key_q.s1coin | joy[JB_S1COIN],
               key_q.start2 | key_q.s2coin | joy[JB_S2COIN],
               key_q.fire   | joy[JB_FIRE],
               key_q.bomb   | joy[JB_BOMB]};

      pause_lvl = key_q.pause | joy[JB_PAUSE];
      pause_d   = pause_q;
      if (bus.pause_clr) begin
         pause_d = 1'b0;
      end else if (pause_lvl && !pause_lvl_q) begin
         pause_d = !pause_q;
      end

      coin_lvl = key_q.coin | key_q.s1coin | key_q.s2coin |
                 joy[JB_COIN] | joy[JB_S1COIN] | joy[JB_S2COIN];
      coin_req = coin_lvl && !coin_lvl_q;
   end

   // armed_q holds off edge detection until old_tog_q has sampled the bus.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_q       <= '0;
         old_tog_q   <= 1'b0;
         armed_q     <= 1'b0;
         joy_q       <= '0;
         ctl_q       <= '0;
         service_q   <= 1'b0;
         pause_q     <= 1'b0;
         pause_lvl_q <= 1'b0;
         coin_lvl_q  <= 1'b0;
      end else begin
         key_q       <= key_d;
         old_tog_q   <= bus.ps2_key[10];
         armed_q     <= 1'b1;
         joy_q       <= joy_d;
         ctl_q       <= ctl_d;
         service_q   <= key_q.service;
         pause_q     <= pause_d;
         pause_lvl_q <= pause_lvl;
         coin_lvl_q  <= coin_lvl;
      end
   end

   coin_pulser #(
      .COIN_PULSE_CYC (COIN_PULSE_CYC),
      .COIN_GAP_CYC   (COIN_GAP_CYC),
      .CNT_W          (CNT_W)
   ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (coin_req),
      .coin    (bus.coin)
   );

   assign bus.joystick = joy_q;
   assign bus.controls = ctl_q;
   assign bus.service  = service_q;
   assign bus.pause    = pause_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed scoreboard bench for arcade_input_ctrl (PULSE=8, GAP=4).
module tb_arcade_input_ctrl;

   logic clk;
   logic rst_n;
   logic tog;

   arcade_input_ctrl_if bus ();

   arcade_input_ctrl #(
      .COIN_PULSE_CYC (8),
      .COIN_GAP_CYC   (4),
      .CNT_W          (21)
   ) dut (
      .clk_sys (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } sb_t;

   sb_t sbq[$];
   int  passed;
   int  failed;
   int  total;

   int rises, highs, cur_run, max_run, lowrun, min_gap;
   logic prev;

   task automatic exp_push(input string t, input logic [31:0] v);
      sb_t e;
      e.tag = t;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      sb_t e;
      total++;
      if (sbq.size() == 0) begin
         e.tag = "sb_empty";
         e.val = 32'hxxxx_xxxx;
      end else begin
         e = sbq.pop_front();
      end
      assert (obs === e.val) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic key(input logic pr, input logic ext, input logic [7:0] code);
      tog = ~tog;
      bus.ps2_key = {tog, pr, ext, code};
   endtask

   task automatic stats_clr();
      rises = 0; highs = 0; cur_run = 0; max_run = 0;
      lowrun = 0; min_gap = 999; prev = bus.coin;
   endtask

   task automatic samp();
      if (bus.coin === 1'b1) begin
         if (prev !== 1'b1) begin
            if (rises > 0 && lowrun < min_gap) min_gap = lowrun;
            rises++;
         end
         highs++;
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
         lowrun = 0;
      end else begin
         cur_run = 0;
         lowrun++;
      end
      prev = bus.coin;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      passed = 0; failed = 0; total = 0;
      tog = 1'b0;
      rst_n = 1'b0;
      bus.ps2_key    = '0;
      bus.joystick_0 = '0;
      bus.joystick_1 = '0;
      bus.rotate     = 1'b0;
      bus.pause_clr  = 1'b0;
      tick(2);

      exp_push("rst_joystick", 0);
      exp_push("rst_controls", 0);
      exp_push("rst_coin", 0);
      exp_push("rst_service", 0);
      exp_push("rst_pause", 0);
      chk(32'(bus.joystick));
      chk(32'(bus.controls));
      chk(32'(bus.coin));
      chk(32'(bus.service));
      chk(32'(bus.pause));

      rst_n = 1'b1;
      tick(3);

      // Extended up key: two-clock latency, then release.
      key(1'b1, 1'b1, 8'h75);
      exp_push("key_up_lat1", 4'b0000);
      exp_push("key_up_press", 4'b1000);
      tick(1);
      chk(32'(bus.joystick));
      tick(1);
      chk(32'(bus.joystick));
      key(1'b0, 1'b1, 8'h75);
      exp_push("key_up_release", 4'b0000);
      tick(2);
      chk(32'(bus.joystick));

      // Fire requires ext=0: extended 029 must be ignored.
      key(1'b1, 1'b1, 8'h29);
      exp_push("ext_fire_ignored", 4'b0000);
      tick(2);
      chk(32'(bus.controls));
      key(1'b1, 1'b0, 8'h16);
      exp_push("key_start1", 4'b1000);
      tick(2);
      chk(32'(bus.controls));
      key(1'b0, 1'b0, 8'h16);
      key_service: begin
         tick(1);
         key(1'b1, 1'b0, 8'h1B);
      end
      exp_push("key_service", 1);
      tick(3);
      chk(32'(bus.service));
      key(1'b0, 1'b0, 8'h1B);
      tick(3);

      // Joystick paths and rotation.
      bus.rotate = 1'b1;
      bus.joystick_0 = 16'h0002;
      exp_push("rot_left_to_up", 4'b1000);
      tick(1);
      chk(32'(bus.joystick));
      bus.joystick_0 = 16'h0000;
      bus.joystick_1 = 16'h0008;
      exp_push("rot_up_to_right", 4'b0100);
      tick(1);
      chk(32'(bus.joystick));
      bus.rotate = 1'b0;
      exp_push("norot_up", 4'b1000);
      tick(1);
      chk(32'(bus.joystick));
      bus.joystick_1 = 16'h0000;
      bus.joystick_0 = 16'h0010;
      exp_push("joy_fire", 4'b0010);
      tick(1);
      chk(32'(bus.controls));
      bus.joystick_0 = 16'h0000;
      tick(2);

      // Pause toggle via keyboard.
      key(1'b1, 1'b0, 8'h4D);
      exp_push("pause_on", 1);
      tick(2);
      chk(32'(bus.pause));
      key(1'b0, 1'b0, 8'h4D);
      tick(2);
      key(1'b1, 1'b0, 8'h4D);
      exp_push("pause_off", 0);
      tick(2);
      chk(32'(bus.pause));
      key(1'b0, 1'b0, 8'h4D);
      tick(2);

      // pause_clr wins over a coincident edge.
      bus.joystick_0 = 16'h0200;
      bus.pause_clr  = 1'b1;
      exp_push("pause_clr_edge", 0);
      tick(1);
      chk(32'(bus.pause));
      bus.joystick_0 = 16'h0000;
      bus.pause_clr  = 1'b0;
      tick(2);

      // Held coin key: exactly one 8-cycle pulse.
      stats_clr();
      exp_push("hold_rises", 1);
      exp_push("hold_highs", 8);
      key(1'b1, 1'b0, 8'h2E);
      for (int i = 0; i < 50; i++) begin
         tick(1);
         samp();
      end
      chk(32'(rises));
      chk(32'(highs));
      key(1'b0, 1'b0, 8'h2E);
      tick(20);

      // Three joystick coin edges two clocks apart.
      stats_clr();
`ifdef COIN_QUEUE_EN
      exp_push("queue_rises", 3);
      exp_push("queue_highs", 24);
`else
      exp_push("queue_rises", 1);
      exp_push("queue_highs", 8);
`endif
      exp_push("queue_max_run", 8);
      exp_push("queue_min_gap_ge4", 1);
      for (int i = 0; i < 6; i++) begin
         bus.joystick_0 = (i % 2 == 0) ? 16'h0100 : 16'h0000;
         tick(1);
         samp();
      end
      for (int i = 0; i < 60; i++) begin
         tick(1);
         samp();
      end
      chk(32'(rises));
      chk(32'(highs));
      chk(32'(max_run));
      chk(32'(min_gap >= 4));
      tick(5);

      // Reset in the middle of a pulse, with a second request outstanding.
      bus.joystick_0 = 16'h0100;
      exp_push("mid_pulse_coin", 1);
      tick(1);
      chk(32'(bus.coin));
      bus.joystick_0 = 16'h0000;
      tick(1);
      bus.joystick_0 = 16'h0100;
      tick(1);
      rst_n = 1'b0;
      bus.joystick_0 = 16'h0000;
      #1;
      exp_push("async_coin_drop", 0);
      exp_push("rst_pending", 0);
      chk(32'(bus.coin));
      chk(32'(dut.u_coin.pending));
      tick(2);
      rst_n = 1'b1;
      stats_clr();
      exp_push("post_rst_no_pulse", 0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         samp();
      end
      chk(32'(rises));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Input-conditioning stage that sits directly upstream of the arcade core's control inputs (joystick, controls, coin, pause).
- Decodes the hps_io ps2_key event bus and merges it with joystick_0/joystick_1.
- Applies orientation remap, toggles pause, and converts coin requests into fixed-width, gap-separated coin pulses the game CPU samples reliably.
- Replaces ad-hoc button latching in the top level with one registered, testable block on clk_sys.

Parameters:
- COIN_PULSE_CYC, 1800000: coin output high time in clk_sys cycles (100 ms at 18 MHz); must be >=1.
- COIN_GAP_CYC, 1800000: mandatory low time after each coin pulse; must be >=1.
- CNT_W, 21: counter width; must hold max(COIN_PULSE_CYC, COIN_GAP_CYC)-1.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [10]=event toggle, [9]=pressed, [8]=extended, [7:0]=scancode
- joystick_0  in  16  player-1 digital inputs from hps_io
- joystick_1  in  16  player-2 digital inputs, ORed with joystick_0
- rotate  in  1  1 = horizontal orientation remap
- pause_clr  in  1  synchronous forced pause clear (OSD reset / user button)
- joystick  out  4  {up,right,down,left}
- controls  out  4  {start1,start2,fire,bomb}
- coin  out  1  conditioned coin pulse
- service  out  1  service key level
- pause  out  1  pause toggle state

Behaviour:
- Reset: all key-state registers, joystick, controls, coin, service and pause go to 0. The old-toggle register loads ps2_key[10] on the first clock after release, so no spurious event is generated. Coin FSM enters IDLE with pending=0.
- Key event:
  - An event is detected when registered old_toggle != ps2_key[10].
  - On the next clock, the matched key register loads ps2_key[9]. Unmatched codes are ignored.
- Key map ({ext,code}; X = either extended value):
  - X75 up, X72 down, X6B left, X74 right
  - 029 fire, X14 bomb
  - 016 start1, 01E start2
  - 02E/036 coin
  - 005 start1+coin, 006 start2+coin
  - 01B service, 04D pause
- Merge: joy = joystick_0 | joystick_1. Joystick bit mapping: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] bomb, [6] start1+coin, [7] start2+coin, [8] coin, [9] pause.
- Rotate=1 remap: up<=left, down<=right, left<=down, right<=up. This applies to both keyboard and joystick sources.
- Outputs are registered. Latency is 1 clock from joystick input and 2 clocks from a ps2_key toggle edge.
- Pause:
  - A rising edge of the raw pause level (key | joy[9]) toggles pause.
  - pause_clr has priority and forces pause to 0 even in the same cycle as an edge.
- Coin FSM:
  - A request is a rising edge of the OR of all coin sources.
  - IDLE: on a request or pending>0, load counter with COIN_PULSE_CYC-1, set coin=1, go to PULSE. If the start came from pending, decrement pending.
  - PULSE: counter decrements. At 0, set coin=0, load COIN_GAP_CYC-1, go to GAP.
  - GAP: counter decrements. At 0, go to IDLE.
  - A request in the same cycle IDLE starts a pulse is consumed by that pulse; it does not also queue.
  - Holding a coin source high produces exactly one pulse.
- Reset asserted mid-pulse drops coin immediately and clears pending.

Optional Feature:
- COIN_QUEUE_EN defined:
  - Requests arriving in PULSE or GAP increment a 2-bit pending counter, saturating at 3.
  - Each queued request yields one further pulse+gap, served in order.
- Undefined:
  - Requests during PULSE/GAP are dropped.
  - The pending logic is absent; pending is constant 0.

Decomposition:
- Package arcade_input_pkg holds:
  - the scancode localparams
  - the joystick bit-index constants
  - the coin FSM state enum {IDLE, PULSE, GAP}
- One natural sub-module: coin_pulser, containing the coin FSM, counter and pending queue, parameterised by COIN_PULSE_CYC/COIN_GAP_CYC.

Test Plan:
- Key press/release: toggle ps2_key[10] with {pressed=1, ext=1, code=75}, rotate=0 -> joystick=4'b1000 two clocks later. Then a release event -> 4'b0000.
- Rotation: rotate=1, joystick_0[1]=1 (left) -> joystick=4'b1000 (up). joystick_1[3]=1 alone -> joystick=4'b0100 (right).
- Coin timing: PULSE=8, GAP=4, one key-02E press held for 50 clocks -> coin high exactly 8 clocks, then low, and no second pulse.
- Coin queueing: PULSE=8, GAP=4, three joy[8] edges 2 clocks apart:
  - COIN_QUEUE_EN -> 3 pulses, each 8 high with >=4 low between.
  - Without the macro -> exactly 1 pulse.
- Pause: two 04D press events -> pause 0->1->0. Pause edge and pause_clr in the same cycle -> pause=0.
- Reset mid-pulse: assert reset_n=0 at clock 3 of a pulse -> coin=0 asynchronously. After release, no pulse unless a new request arrives. Pending reads 0.
